// File: rtl/fft_pkg.sv
// Shared FFT constants: default frame size, sample width and derived widths.
package fft_pkg;

  localparam int FFT_LOGN        = 4;
  localparam int FFT_DATA_WIDTH  = 16;
  localparam int FFT_N           = 1 << FFT_LOGN;
  localparam int FFT_POWER_WIDTH = 2 * FFT_DATA_WIDTH;

endpackage

// File: rtl/cplx_mag_sq.sv
// Two-stage registered |z|^2 pipeline with valid/ready handshake and a
// pass-through tag that travels alongside each sample.
module cplx_mag_sq
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int TAG_WIDTH  = FFT_LOGN + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   s_real,
  input  logic [DATA_WIDTH-1:0]   s_imag,
  input  logic [TAG_WIDTH-1:0]    s_tag,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [2*DATA_WIDTH-1:0] m_power,
  output logic [TAG_WIDTH-1:0]    m_tag,
  output logic                    m_valid,
  input  logic                    m_ready
);

  localparam int SQ_W = 2 * DATA_WIDTH - 1;
  localparam int PW   = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] re_abs, im_abs;
  logic [PW-1:0]         re_ext, im_ext;
  logic [SQ_W-1:0]       re_sq_c, im_sq_c;
  logic [SQ_W-1:0]       re_sq, im_sq;
  logic [TAG_WIDTH-1:0]  s1_tag;
  logic                  s1_valid;
  logic                  load1, load2;

  // Squares are taken on magnitudes so the most negative input (-2^(W-1))
  // squares to 2^(2W-2), which still fits in 2W-1 unsigned bits.
  always_comb begin
    re_abs  = s_real[DATA_WIDTH-1] ? (~s_real + 1'b1) : s_real;
    im_abs  = s_imag[DATA_WIDTH-1] ? (~s_imag + 1'b1) : s_imag;
    re_ext  = {{DATA_WIDTH{1'b0}}, re_abs};
    im_ext  = {{DATA_WIDTH{1'b0}}, im_abs};
    re_sq_c = SQ_W'(re_ext * re_ext);
    im_sq_c = SQ_W'(im_ext * im_ext);
  end

  assign load2   = !m_valid || m_ready;
  assign load1   = !s1_valid || load2;
  assign s_ready = load1 && !clear;

  // Stage 1: register both squares and the tag when the stage can advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      re_sq    <= '0;
      im_sq    <= '0;
      s1_tag   <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else if (load1) begin
      s1_valid <= s_valid;
      if (s_valid) begin
        re_sq  <= re_sq_c;
        im_sq  <= im_sq_c;
        s1_tag <= s_tag;
      end
    end
  end

  // Stage 2: register the full-width sum; holds its data while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_power <= '0;
      m_tag   <= '0;
    end else if (clear) begin
      m_valid <= 1'b0;
    end else if (load2) begin
      m_valid <= s1_valid;
      if (s1_valid) begin
        m_power <= {1'b0, re_sq} + {1'b0, im_sq};
        m_tag   <= s1_tag;
      end
    end
  end

endmodule

// File: rtl/fft_power_peak.sv
// Per-bin power of an FFT frame plus tracking of the strongest bin per frame.
module fft_power_peak
  import fft_pkg::*;
#(
  parameter int LOGN       = FFT_LOGN,
  parameter int DATA_WIDTH = FFT_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   s_real,
  input  logic [DATA_WIDTH-1:0]   s_imag,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [2*DATA_WIDTH-1:0] m_power,
  output logic [LOGN-1:0]         m_bin,
  output logic                    m_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2*DATA_WIDTH-1:0] peak_power,
  output logic [LOGN-1:0]         peak_bin,
  output logic                    peak_valid
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int TW = LOGN + 1;

  logic [LOGN-1:0] bin_cnt;
  logic [TW-1:0]   in_tag, out_tag;
  logic            in_xfer, out_xfer;
  logic [PW-1:0]   run_max, cand_power;
  logic [LOGN-1:0] run_bin, cand_bin;

  // The tag carries the last-bin flag above the bin index.
  assign in_tag   = {&bin_cnt, bin_cnt};
  assign m_last   = out_tag[LOGN];
  assign m_bin    = out_tag[LOGN-1:0];
  assign in_xfer  = s_valid && s_ready;
  assign out_xfer = m_valid && m_ready && !clear;

  cplx_mag_sq #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_WIDTH  (TW)
  ) u_mag_sq (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .s_real  (s_real),
    .s_imag  (s_imag),
    .s_tag   (in_tag),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_power (m_power),
    .m_tag   (out_tag),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  // Bin counter tags each accepted sample and wraps naturally at N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_cnt <= '0;
    end else if (clear) begin
      bin_cnt <= '0;
    end else if (in_xfer) begin
      bin_cnt <= bin_cnt + 1'b1;
    end
  end

  // Candidate max: bin 0 always starts a fresh frame; ties keep the earlier bin.
  always_comb begin
    cand_power = run_max;
    cand_bin   = run_bin;
    if ((m_bin == '0) || (m_power > run_max)) begin
      cand_power = m_power;
      cand_bin   = m_bin;
    end
  end

  // Running max per frame; publish it with a one-cycle pulse after the last bin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max    <= '0;
      run_bin    <= '0;
      peak_power <= '0;
      peak_bin   <= '0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      if (clear) begin
        run_max <= '0;
        run_bin <= '0;
      end else if (out_xfer) begin
        if (m_last) begin
          peak_power <= cand_power;
          peak_bin   <= cand_bin;
          peak_valid <= 1'b1;
          run_max    <= '0;
          run_bin    <= '0;
        end else begin
          run_max <= cand_power;
          run_bin <= cand_bin;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_power_peak.sv
// Randomized and directed bench for fft_power_peak with a queue-based model.
module tb_fft_power_peak;

  localparam int N  = 16;
  localparam int DW = 16;

  logic            clk;
  logic            rst;
  logic            clear;
  logic [DW-1:0]   s_real, s_imag;
  logic            s_valid, s_ready;
  logic [2*DW-1:0] m_power;
  logic [3:0]      m_bin;
  logic            m_last, m_valid, m_ready;
  logic [2*DW-1:0] peak_power;
  logic [3:0]      peak_bin;
  logic            peak_valid;

  typedef struct {
    longint power;
    int     bin;
    bit     last;
    int     cyc;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   frame_q[$];
  int     pulse_cycles[$];
  int     checks = 0;
  int     failures = 0;
  int     cycle = 0;
  int     model_cnt = 0;
  bit     exp_pulse = 0;
  longint exp_peak_power = 0;
  int     exp_peak_bin = 0;
  bit     lat_check = 0;
  bit     accepted = 0;
  bit     toggle_state = 0;

  fft_power_peak #(
    .LOGN       (4),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .s_real     (s_real),
    .s_imag     (s_imag),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_power    (m_power),
    .m_bin      (m_bin),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .peak_power (peak_power),
    .peak_bin   (peak_bin),
    .peak_valid (peak_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic longint model_power(input int re, input int im);
    return longint'(re) * longint'(re) + longint'(im) * longint'(im);
  endfunction

  // Largest power in a completed frame, earliest bin wins a tie.
  task automatic finish_frame();
    longint best = -1;
    int     best_bin = 0;
    foreach (frame_q[i]) begin
      if (frame_q[i].power > best) begin
        best     = frame_q[i].power;
        best_bin = frame_q[i].bin;
      end
    end
    exp_pulse      = 1;
    exp_peak_power = best;
    exp_peak_bin   = best_bin;
    frame_q.delete();
  endtask

  // Observe one cycle at the falling edge, update the model, advance past the rising edge.
  task automatic tick(input int re, input int im);
    exp_t item;
    bit   in_xfer, out_xfer;
    @(negedge clk);
    cycle++;
    checkOutput("peak_valid", peak_valid, exp_pulse);
    checkOutput("peak_power", peak_power, exp_peak_power);
    checkOutput("peak_bin", peak_bin, exp_peak_bin);
    if (peak_valid) pulse_cycles.push_back(cycle);
    exp_pulse = 0;
    checkOutput("s_ready", s_ready, (!clear && (exp_q.size() < 2 || m_ready)) ? 1 : 0);
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("m_valid_spurious", m_valid, 0);
      end else begin
        checkOutput("m_power", m_power, exp_q[0].power);
        checkOutput("m_bin", m_bin, exp_q[0].bin);
        checkOutput("m_last", m_last, exp_q[0].last);
      end
    end
    out_xfer = m_valid && m_ready && !clear;
    in_xfer  = s_valid && s_ready;
    if (out_xfer && exp_q.size() > 0) begin
      item = exp_q.pop_front();
      if (lat_check) checkOutput("latency", cycle - item.cyc, 2);
      frame_q.push_back(item);
      if (item.last) finish_frame();
    end
    if (in_xfer) begin
      accepted = 1;
      item.power = model_power(re, im);
      item.bin   = model_cnt;
      item.last  = (model_cnt == N - 1);
      item.cyc   = cycle;
      exp_q.push_back(item);
      model_cnt = (model_cnt + 1) % N;
    end
    if (clear) begin
      exp_q.delete();
      frame_q.delete();
      model_cnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit valid, input int re, input int im, input bit rdy, input bit clr);
    s_valid = valid;
    s_real  = DW'(re);
    s_imag  = DW'(im);
    m_ready = rdy;
    clear   = clr;
    tick(re, im);
  endtask

  // 0: always ready, 1: toggle every cycle, 2: random.
  function automatic bit pick_ready(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) begin
      toggle_state = ~toggle_state;
      return toggle_state;
    end
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic send_bin(input int re, input int im, input int mode);
    int budget = 0;
    accepted = 0;
    while (!accepted && budget < 40) begin
      applyStimulus(1'b1, re, im, pick_ready(mode), 1'b0);
      budget++;
    end
    checkOutput("send_timeout", accepted, 1);
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
      budget++;
    end
    checkOutput("drain_timeout", exp_q.size(), 0);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset, checked before any clock edge can act.
  task automatic do_reset();
    rst = 1'b1;
    #3;
    exp_q.delete();
    frame_q.delete();
    model_cnt      = 0;
    exp_pulse      = 0;
    exp_peak_power = 0;
    exp_peak_bin   = 0;
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_power", m_power, 0);
    checkOutput("rst_m_bin", m_bin, 0);
    checkOutput("rst_peak_valid", peak_valid, 0);
    checkOutput("rst_peak_power", peak_power, 0);
    checkOutput("rst_peak_bin", peak_bin, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic random_frame(input int mode);
    for (int k = 0; k < N; k++)
      send_bin($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, mode);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; s_valid = 1'b0; s_real = '0; s_imag = '0; m_ready = 1'b1;
    do_reset();

    $display("[TB] ramp frame");
    lat_check = 1;
    for (int k = 0; k < N; k++) send_bin(k * 256, 0, 0);
    drain();
    checkOutput("ramp_peak_power", peak_power, 14745600);
    checkOutput("ramp_peak_bin", peak_bin, 15);
    checkOutput("ramp_pulse_count", pulse_cycles.size(), 1);
    lat_check = 0;

    $display("[TB] most negative input");
    send_bin(-32768, -32768, 0);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    checkOutput("max_power", m_power, 64'h8000_0000);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);

    $display("[TB] tie frame with toggled m_ready");
    for (int k = 0; k < N; k++) begin
      if (k == 3 || k == 9) send_bin(30, -10, 1);
      else send_bin($urandom_range(0, 20), $urandom_range(0, 20), 1);
    end
    drain();
    checkOutput("tie_peak_bin", peak_bin, 3);
    checkOutput("tie_peak_power", peak_power, 1000);

    $display("[TB] back-to-back frames");
    pulse_cycles.delete();
    lat_check = 1;
    random_frame(0);
    random_frame(0);
    drain();
    lat_check = 0;
    checkOutput("b2b_pulse_count", pulse_cycles.size(), 2);
    if (pulse_cycles.size() == 2)
      checkOutput("b2b_pulse_gap", pulse_cycles[1] - pulse_cycles[0], 16);

    $display("[TB] clear mid-frame");
    for (int k = 0; k < 8; k++) send_bin(20000, 20000, 0);
    applyStimulus(1'b1, 5, 5, 1'b1, 1'b1);
    random_frame(2);
    drain();

    $display("[TB] reset mid-frame");
    for (int k = 0; k < 8; k++) send_bin(20000, -20000, 0);
    do_reset();
    random_frame(2);
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0),
                    $urandom_range(0, 65535) - 32768,
                    $urandom_range(0, 65535) - 32768,
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 63) == 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_power_peak.md
FFT_POWER_PEAK -- requirements
Module: fft_power_peak

Interface
REQ-001 SHALL have parameter LOGN, default 4, meaning log2 of frame length N (N = 2^LOGN bins).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning signed Q1.15 width of each real/imag input.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clear  input  1  synchronous flush of pipeline, bin counter and peak tracker.
REQ-006 SHALL have port s_real  input  DATA_WIDTH  signed real part of FFT bin.
REQ-007 SHALL have port s_imag  input  DATA_WIDTH  signed imaginary part of FFT bin.
REQ-008 SHALL have port s_valid  input  1  input bin valid.
REQ-009 SHALL have port s_ready  output  1  block accepts input bin.
REQ-010 SHALL have port m_power  output  2*DATA_WIDTH  unsigned re^2+im^2.
REQ-011 SHALL have port m_bin  output  LOGN  bin index of m_power.
REQ-012 SHALL have port m_last  output  1  marks bin N-1 of a frame.
REQ-013 SHALL have port m_valid  output  1  output bin valid.
REQ-014 SHALL have port m_ready  input  1  downstream accepts output bin.
REQ-015 SHALL have port peak_power  output  2*DATA_WIDTH  largest power of last completed frame.
REQ-016 SHALL have port peak_bin  output  LOGN  bin index of peak_power.
REQ-017 SHALL have port peak_valid  output  1  one-cycle pulse when peak_power/peak_bin update.

Function
REQ-018 An input transfer SHALL occur on a clock edge with s_valid && s_ready; an output transfer on m_valid && m_ready.
REQ-019 Datapath SHALL be a 2-stage pipeline: stage 1 registers re^2 and im^2 (each 2*DATA_WIDTH-1 bits unsigned) plus bin/last; stage 2 registers their sum into m_power.
REQ-020 Sum SHALL be computed without saturation; (-2^15)^2 + (-2^15)^2 = 2^31 SHALL fit exactly in 32 bits.
REQ-021 Latency SHALL be 2 cycles from input transfer to m_valid when m_ready is held high.
REQ-022 Stage 2 SHALL load when !m_valid || m_ready; stage 1 SHALL load when its valid is low or stage 2 loads; s_ready SHALL equal the stage-1 load condition and SHALL be 0 while clear is high.
REQ-023 Throughput SHALL be one bin per cycle with no bubbles when m_ready is continuously high.
REQ-024 m_power, m_bin, m_last SHALL hold stable while m_valid && !m_ready.
REQ-025 Bin counter SHALL increment on each input transfer, wrap N-1 -> 0, and tag the transferred bin with its current value; m_last SHALL be 1 iff tagged bin is N-1.
REQ-026 Peak tracker SHALL update on output transfers: replace running max when m_power is strictly greater, so ties keep the lower bin; first bin of a frame SHALL always load.
REQ-027 On output transfer with m_last=1, the cycle after SHALL present the frame's final max on peak_power/peak_bin with peak_valid=1 for exactly one cycle, and running max SHALL restart for the next frame.
REQ-028 peak_power/peak_bin SHALL hold between peak_valid pulses.
REQ-029 clear SHALL drop all in-flight bins (stage valids to 0, m_valid to 0), reset bin counter and running max, suppress peak_valid, and leave peak_power/peak_bin unchanged; clear SHALL win over simultaneous s_valid and m_ready.

Reset
REQ-030 On rst high, asynchronously: stage valids, m_valid, peak_valid = 0; m_power, m_bin, m_last, peak_power, peak_bin = 0; bin counter and running max = 0.
REQ-031 rst asserted mid-frame SHALL discard the partial frame; the first input after release SHALL be tagged bin 0.

Structure
REQ-032 Shared package fft_pkg SHALL hold default LOGN, DATA_WIDTH and the derived N and power width 2*DATA_WIDTH, common with fft.
REQ-033 A single sub-module cplx_mag_sq (2-stage registered squarer/adder with valid-ready pipeline) SHALL be instantiated; bin counter and peak tracker live in the top.

Verification
REQ-034 Reset then frame of 16 bins (re=k*256, im=0), m_ready=1 -> m_power[k]=k^2*65536 two cycles after each input, m_last at bin 15, peak_bin=15, peak_power=14745600, peak_valid one cycle.
REQ-035 Single bin re=im=-32768 -> m_power=0x80000000, no overflow.
REQ-036 m_ready toggled 1/0 each cycle over a 16-bin frame -> no lost or duplicated bins, outputs stable while stalled, s_ready low when both stages full.
REQ-037 Frame with bins 3 and 9 equal at maximum 1000 -> peak_bin=3.
REQ-038 Two back-to-back frames, m_ready=1 -> m_bin wraps 15 -> 0 without gap, two peak_valid pulses 16 cycles apart.
REQ-039 clear (and separately rst) asserted after bin 7 -> m_valid drops, no peak_valid, next frame starts at bin 0 and reports correct peak.
